// File: rtl/seq_udiv_unsign_if.sv
// Operand/result handshake bundle for seq_udiv_unsign.
// The DUT side uses the slave modport; the producer/consumer side uses master.
interface seq_udiv_unsign_if #(
    parameter int unsigned WIDTH = 24
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_valid;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_out_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_div_zero
    );

    modport master (
        output i_valid, i_dividend, i_divisor, i_out_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_div_zero
    );
endinterface

// File: rtl/seq_udiv_unsign.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module seq_udiv_unsign #(
    parameter int unsigned WIDTH = 24
) (
    input logic              i_clk,
    input logic              i_rst,
    seq_udiv_unsign_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   trial;

    // The partial remainder is held in WIDTH bits: it stays below the divisor,
    // so the top bit of the WIDTH+1-bit remainder is always zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dr_q    <= dr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dr_d    = dr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        trial   = {r_q, q_q[WIDTH-1]} - {1'b0, dr_q};

        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    q_d   = bus.i_dividend;
                    r_d   = '0;
                    dr_d  = bus.i_divisor;
                    cnt_d = '0;
                    if (bus.i_divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = bus.i_dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                    dz_d    = 1'b0;
                end
            end
            DONE: begin
                if (bus.i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_quotient  = quo_q;
    assign bus.o_remainder = rem_q;
    assign bus.o_div_zero  = dz_q;
endmodule

// File: tb/tb_seq_udiv_unsign.sv
// Scoreboard bench for seq_udiv_unsign: directed cases on an 8-bit instance,
// back-pressure and randomized traffic on a 24-bit instance.
module tb_seq_udiv_unsign;
    localparam int unsigned NRAND = 1500;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        drv_done;

    always #5 clk = ~clk;

    seq_udiv_unsign_if #(.WIDTH(8))  b8 ();
    seq_udiv_unsign_if #(.WIDTH(24)) b24 ();

    seq_udiv_unsign #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(b8));
    seq_udiv_unsign #(.WIDTH(24)) dut24 (.i_clk(clk), .i_rst(rst), .bus(b24));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb8[$];
    exp_t sb24[$];
    exp_t m8;
    exp_t m24;

    function automatic exp_t model(input logic [31:0] n, input logic [31:0] d,
                                   input int unsigned w);
        exp_t e;
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        if (d == 32'd0) begin
            e.q  = mask;
            e.r  = n;
            e.dz = 1'b1;
        end else begin
            e.q  = n / d;
            e.r  = n % d;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Output-side scoreboards: compare whenever a result handshake is about to occur.
    always @(negedge clk) begin
        if (rst === 1'b0 && b8.o_valid === 1'b1 && b8.i_out_ready === 1'b1) begin
            chk("sb8_pending", 64'(sb8.size() != 0), 64'd1);
            if (sb8.size() != 0) begin
                m8 = sb8.pop_front();
                chk("q8", 64'(b8.o_quotient), 64'(m8.q));
                chk("r8", 64'(b8.o_remainder), 64'(m8.r));
                chk("dz8", 64'(b8.o_div_zero), 64'(m8.dz));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && b24.o_valid === 1'b1 && b24.i_out_ready === 1'b1) begin
            chk("sb24_pending", 64'(sb24.size() != 0), 64'd1);
            if (sb24.size() != 0) begin
                m24 = sb24.pop_front();
                chk("q24", 64'(b24.o_quotient), 64'(m24.q));
                chk("r24", 64'(b24.o_remainder), 64'(m24.r));
                chk("dz24", 64'(b24.o_div_zero), 64'(m24.dz));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; the accept happens on the next edge.
    task automatic send8(input logic [7:0] n, input logic [7:0] d);
        int unsigned w = 0;
        while (!b8.o_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rdy8", 64'(b8.o_ready), 64'd1);
        b8.i_valid    = 1'b1;
        b8.i_dividend = n;
        b8.i_divisor  = d;
        sb8.push_back(model({24'd0, n}, {24'd0, d}, 8));
        @(posedge clk); #1;
        b8.i_valid = 1'b0;
    endtask

    task automatic send24(input logic [23:0] n, input logic [23:0] d);
        int unsigned w = 0;
        while (!b24.o_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rdy24", 64'(b24.o_ready), 64'd1);
        b24.i_valid    = 1'b1;
        b24.i_dividend = n;
        b24.i_divisor  = d;
        sb24.push_back(model({8'd0, n}, {8'd0, d}, 24));
        @(posedge clk); #1;
        b24.i_valid = 1'b0;
    endtask

    // One 8-bit division with i_out_ready held high; latency counted in cycles after accept.
    task automatic op8(input logic [7:0] n, input logic [7:0] d, input int unsigned exp_lat);
        int unsigned lat = 0;
        exp_t e;
        e = model({24'd0, n}, {24'd0, d}, 8);
        send8(n, d);
        @(negedge clk);
        while (!b8.o_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        chk("lat8", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        chk("valid_one_cycle8", 64'(b8.o_valid), 64'd0);
        chk("ready_again8", 64'(b8.o_ready), 64'd1);
        chk("hold_q8", 64'(b8.o_quotient), 64'(e.q));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int unsigned w;
        logic [31:0] rn;
        logic [31:0] rd;
        logic [23:0] n;
        logic [23:0] d;

        rst             = 1'b1;
        drv_done        = 1'b0;
        b8.i_valid      = 1'b0;
        b8.i_dividend   = '0;
        b8.i_divisor    = '0;
        b8.i_out_ready  = 1'b1;
        b24.i_valid     = 1'b0;
        b24.i_dividend  = '0;
        b24.i_divisor   = '0;
        b24.i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_valid8", 64'(b8.o_valid), 64'd0);
        chk("rst_ready8", 64'(b8.o_ready), 64'd1);
        chk("rst_q8", 64'(b8.o_quotient), 64'd0);
        chk("rst_r8", 64'(b8.o_remainder), 64'd0);
        chk("rst_dz8", 64'(b8.o_div_zero), 64'd0);
        chk("rst_valid24", 64'(b24.o_valid), 64'd0);
        chk("rst_ready24", 64'(b24.o_ready), 64'd1);
        @(posedge clk); #1;

        op8(8'd200, 8'd7, 8);
        op8(8'd5, 8'd9, 8);
        op8(8'd255, 8'd1, 8);
        op8(8'd255, 8'd255, 8);
        op8(8'd0, 8'd3, 8);
        op8(8'd13, 8'd0, 0);
        op8(8'd12, 8'd4, 8);

        // Abort mid-calculation: the pending result must never appear.
        send8(8'd100, 8'd3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        sb8.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid8", 64'(b8.o_valid), 64'd0);
        chk("abort_ready8", 64'(b8.o_ready), 64'd1);
        chk("abort_q8", 64'(b8.o_quotient), 64'd0);
        chk("abort_r8", 64'(b8.o_remainder), 64'd0);
        chk("abort_dz8", 64'(b8.o_div_zero), 64'd0);
        repeat (12) begin
            @(negedge clk);
            chk("no_stale8", 64'(b8.o_valid), 64'd0);
        end
        @(posedge clk); #1;
        op8(8'd100, 8'd3, 8);

        // Back-pressure on the 24-bit instance with new operands offered meanwhile.
        b24.i_out_ready = 1'b0;
        e = model(32'hFFFFFF, 32'h3, 24);
        send24(24'hFFFFFF, 24'h000003);
        w = 0;
        @(negedge clk);
        while (!b24.o_valid && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk("lat24", 64'(w), 64'd24);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rn = $urandom;
            b24.i_valid    = 1'b1;
            b24.i_dividend = rn[23:0];
            b24.i_divisor  = 24'd5;
            @(negedge clk);
            chk("bp_valid24", 64'(b24.o_valid), 64'd1);
            chk("bp_ready24", 64'(b24.o_ready), 64'd0);
            chk("bp_q24", 64'(b24.o_quotient), 64'(e.q));
            chk("bp_r24", 64'(b24.o_remainder), 64'(e.r));
        end
        @(posedge clk); #1;
        b24.i_valid     = 1'b0;
        b24.i_out_ready = 1'b1;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("no_ghost24", 64'(b24.o_valid), 64'd0);
            chk("idle_ready24", 64'(b24.o_ready), 64'd1);
        end
        @(posedge clk); #1;

        // Random traffic with random result back-pressure.
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    rn = $urandom;
                    rd = $urandom;
                    n  = rn[23:0];
                    d  = rd[23:0];
                    case ($urandom_range(0, 7))
                        0: d = '0;
                        1: begin
                            n = 24'($urandom_range(0, 1000));
                            d = n + 24'd1 + 24'($urandom_range(0, 1000));
                        end
                        2: n = '1;
                        3: d = '1;
                        4: d = n;
                        5: d = 24'($urandom_range(1, 15));
                        default: ;
                    endcase
                    send24(n, d);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    b24.i_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                b24.i_out_ready = 1'b1;
            end
        join

        w = 0;
        while (sb24.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain24", 64'(sb24.size()), 64'd0);
        chk("drain8", 64'(sb8.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
